// File: rtl/amm_ctrl_arbiter_if.sv
// amm_ctrl_arbiter_if: requester-side and master-side Avalon-MM signals of the control arbiter
interface amm_ctrl_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
);
  logic [NUM_REQ-1:0]        s_write;
  logic [NUM_REQ-1:0]        s_read;
  logic [NUM_REQ*ADDR_W-1:0] s_address;
  logic [NUM_REQ*DATA_W-1:0] s_writedata;
  logic [NUM_REQ-1:0]        s_waitrequest;
  logic [NUM_REQ-1:0]        s_readdatavalid;
  logic [DATA_W-1:0]         s_readdata;
  logic [NUM_REQ-1:0]        s_timeout;
  logic                      m_write;
  logic                      m_read;
  logic [ADDR_W-1:0]         m_address;
  logic [DATA_W-1:0]         m_writedata;
  logic                      m_waitrequest;
  logic                      m_readdatavalid;
  logic [DATA_W-1:0]         m_readdata;
  // The arbiter is the Avalon master towards the control slaves.
  modport master (
    input  s_write, s_read, s_address, s_writedata, m_waitrequest, m_readdatavalid, m_readdata,
    output s_waitrequest, s_readdatavalid, s_readdata, s_timeout, m_write, m_read, m_address, m_writedata
  );
  modport slave (
    output s_write, s_read, s_address, s_writedata, m_waitrequest, m_readdatavalid, m_readdata,
    input  s_waitrequest, s_readdatavalid, s_readdata, s_timeout, m_write, m_read, m_address, m_writedata
  );
endinterface

// File: rtl/amm_ctrl_arbiter.sv
// amm_ctrl_arbiter: round-robin share of one Avalon-MM control master with read routing and watchdog
module amm_ctrl_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int TIMEOUT_W = 16,
  parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(32'hDEAD_BEEF)
) (
  input  logic                clock,
  input  logic                reset_n,
  amm_ctrl_arbiter_if.master  bus
);
  localparam int PW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  // Last watchdog value before abort: a transaction may spend 2**TIMEOUT_W-1 cycles in CMD/RESP.
  localparam logic [TIMEOUT_W-1:0] WD_LAST = ~TIMEOUT_W'(1);

  typedef enum logic [1:0] {IDLE, CMD, RESP} state_t;

  state_t               state_q, state_d;
  logic [PW-1:0]        rr_ptr_q, rr_ptr_d, g_q, g_d, win, g_next;
  logic [TIMEOUT_W-1:0] wd_q, wd_d;
  logic                 m_write_q, m_write_d, m_read_q, m_read_d;
  logic [ADDR_W-1:0]    m_address_q, m_address_d;
  logic [DATA_W-1:0]    m_writedata_q, m_writedata_d;
  logic [NUM_REQ-1:0]   req, rdv_q, rdv_d, tout_q, tout_d, s_wait;
  logic [DATA_W-1:0]    rdata_q, rdata_d;
  logic                 found, accept, expire;

  assign req    = bus.s_read | bus.s_write;
  assign accept = state_q == CMD && (m_write_q | m_read_q) && !bus.m_waitrequest;
  assign expire = wd_q == WD_LAST;
  assign g_next = g_q == PW'(NUM_REQ - 1) ? '0 : g_q + 1'b1;

  // Round-robin search starting at rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    int idx;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      idx = idx >= NUM_REQ ? idx - NUM_REQ : idx;
      if (!found && req[PW'(idx)]) begin
        found = 1'b1;
        win   = PW'(idx);
      end
    end
  end

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next state: a write completes on accept, a read waits for its response; the watchdog aborts either phase.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = found ? CMD : IDLE;
      CMD:     state_d = accept ? (m_write_q ? IDLE : RESP) : (expire ? IDLE : CMD);
      RESP:    state_d = (bus.m_readdatavalid || expire) ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end

  // Outputs and datapath next values; a real response in the expiry cycle beats the abort.
  always_comb begin
    m_write_d     = m_write_q;
    m_read_d      = m_read_q;
    m_address_d   = m_address_q;
    m_writedata_d = m_writedata_q;
    g_d           = g_q;
    rr_ptr_d      = rr_ptr_q;
    rdv_d         = '0;
    tout_d        = '0;
    rdata_d       = rdata_q;
    s_wait        = '1;
    wd_d          = state_q == IDLE ? '0 : wd_q + 1'b1;
    if (state_q == IDLE && found) begin
      g_d           = win;
      m_write_d     = bus.s_write[win];
      m_read_d      = !bus.s_write[win];
      m_address_d   = bus.s_address[int'(win)*ADDR_W +: ADDR_W];
      m_writedata_d = bus.s_writedata[int'(win)*DATA_W +: DATA_W];
    end
    if (state_q == CMD && (accept || expire)) begin
      m_write_d    = 1'b0;
      m_read_d     = 1'b0;
      s_wait[g_q]  = 1'b0;
      rr_ptr_d     = (!accept || m_write_q) ? g_next : rr_ptr_q;
      tout_d[g_q]  = !accept;
    end
    if (state_q == RESP && (bus.m_readdatavalid || expire)) begin
      rr_ptr_d    = g_next;
      rdv_d[g_q]  = 1'b1;
      rdata_d     = bus.m_readdatavalid ? bus.m_readdata : ERR_DATA;
      tout_d[g_q] = !bus.m_readdatavalid;
    end
  end

  // Datapath registers; reset drops any transaction in flight without a response.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_write_q     <= 1'b0;
      m_read_q      <= 1'b0;
      m_address_q   <= '0;
      m_writedata_q <= '0;
      g_q           <= '0;
      rr_ptr_q      <= '0;
      wd_q          <= '0;
      rdv_q         <= '0;
      tout_q        <= '0;
      rdata_q       <= '0;
    end else begin
      m_write_q     <= m_write_d;
      m_read_q      <= m_read_d;
      m_address_q   <= m_address_d;
      m_writedata_q <= m_writedata_d;
      g_q           <= g_d;
      rr_ptr_q      <= rr_ptr_d;
      wd_q          <= wd_d;
      rdv_q         <= rdv_d;
      tout_q        <= tout_d;
      rdata_q       <= rdata_d;
    end
  end

  assign bus.m_write         = m_write_q;
  assign bus.m_read          = m_read_q;
  assign bus.m_address       = m_address_q;
  assign bus.m_writedata     = m_writedata_q;
  assign bus.s_waitrequest   = s_wait;
  assign bus.s_readdatavalid = rdv_q;
  assign bus.s_readdata      = rdata_q;
  assign bus.s_timeout       = tout_q;
endmodule
